branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_pkg.sv | 27 ++
 rtl/branch_ctrl_cmp.sv | 27 ++
 rtl/branch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_branch_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared pipeline definitions for the branch controller: op encoding, FSM states
// and the target alignment helper.
package branch_ctrl_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_BEQ  = 3'b001,
      BR_BNE  = 3'b010,
      BR_BLT  = 3'b011,
      BR_BGE  = 3'b100,
      BR_BLTU = 3'b101,
      BR_BGEU = 3'b110,
      BR_RSVD = 3'b111
   } br_op_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_OPS = 2'd1,
      ST_RESOLVE  = 2'd2,
      ST_REDIRECT = 2'd3
   } br_state_e;

   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Combinational branch condition evaluator: signed compares for blt/bge,
// unsigned for bltu/bgeu, none/reserved never taken.
module br_cmp
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  br_op_e          op,
   output logic            taken
);

   always_comb begin
      taken = 1'b0;
      case (op)
         BR_BEQ:  taken = (a == b);
         BR_BNE:  taken = (a != b);
         BR_BLT:  taken = ($signed(a) <  $signed(b));
         BR_BGE:  taken = ($signed(a) >= $signed(b));
         BR_BLTU: taken = (a <  b);
         BR_BGEU: taken = (a >= b);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: accepts a branch from decode, collects operands,
// resolves it and drives the fetch redirect; keeps resolved/taken statistics.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_op,
   input  logic [XLEN-1:0]  br_pc,
   input  logic [XLEN-1:0]  br_imm,
   input  logic             rs1_rdy,
   input  logic             rs2_rdy,
   input  logic [XLEN-1:0]  rs1_val,
   input  logic [XLEN-1:0]  rs2_val,
   input  logic             kill,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush_if_id,
   output logic             done,
   output logic             misalign,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   br_state_e        state_q, state_d;
   br_op_e           op_q, op_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   logic [XLEN-1:0]  rs1_q, rs1_d;
   logic [XLEN-1:0]  rs2_q, rs2_d;
   logic             have1_q, have1_d;
   logic             have2_q, have2_d;
   logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
   logic             done_q, done_d;
   logic             flush_q, flush_d;
   logic             mis_q, mis_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   logic             cmp_taken;
   logic [XLEN-1:0]  target;

   br_cmp #(.XLEN(XLEN)) u_cmp (
      .a     (rs1_q),
      .b     (rs2_q),
      .op    (op_q),
      .taken (cmp_taken)
   );

   assign target = pc_q + imm_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      pc_d        = pc_q;
      imm_d       = imm_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      have1_d     = have1_q;
      have2_d     = have2_q;
      redir_pc_d  = redir_pc_q;
      done_d      = 1'b0;
      flush_d     = 1'b0;
      mis_d       = 1'b0;
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (br_valid) begin
               op_d    = br_op_e'(br_op);
               pc_d    = br_pc;
               imm_d   = br_imm;
               have1_d = rs1_rdy;
               have2_d = rs2_rdy;
               if (rs1_rdy) rs1_d = rs1_val;
               if (rs2_rdy) rs2_d = rs2_val;
               state_d = (rs1_rdy && rs2_rdy) ? ST_RESOLVE : ST_WAIT_OPS;
            end
         end
         ST_WAIT_OPS: begin
            if (!have1_q && rs1_rdy) begin
               rs1_d   = rs1_val;
               have1_d = 1'b1;
            end
            if (!have2_q && rs2_rdy) begin
               rs2_d   = rs2_val;
               have2_d = 1'b1;
            end
            if (have1_d && have2_d) state_d = ST_RESOLVE;
         end
         ST_RESOLVE: begin
            if (!cmp_taken) begin
               done_d   = 1'b1;
               br_cnt_d = br_cnt_q + CNT_W'(1);
               state_d  = ST_IDLE;
            end else if (!is_aligned(target[1:0])) begin
               mis_d       = 1'b1;
               done_d      = 1'b1;
               br_cnt_d    = br_cnt_q + CNT_W'(1);
               taken_cnt_d = taken_cnt_q + CNT_W'(1);
               state_d     = ST_IDLE;
            end else begin
               redir_pc_d = target;
               flush_d    = 1'b1;
               state_d    = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) begin
               done_d      = 1'b1;
               br_cnt_d    = br_cnt_q + CNT_W'(1);
               taken_cnt_d = taken_cnt_q + CNT_W'(1);
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A flush from an older instruction overrides any resolution or handshake.
      if (kill && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         done_d      = 1'b0;
         flush_d     = 1'b0;
         mis_d       = 1'b0;
         redir_pc_d  = redir_pc_q;
         br_cnt_d    = br_cnt_q;
         taken_cnt_d = taken_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= BR_NONE;
         pc_q        <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         have1_q     <= 1'b0;
         have2_q     <= 1'b0;
         redir_pc_q  <= '0;
         done_q      <= 1'b0;
         flush_q     <= 1'b0;
         mis_q       <= 1'b0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         pc_q        <= pc_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         have1_q     <= have1_d;
         have2_q     <= have2_d;
         redir_pc_q  <= redir_pc_d;
         done_q      <= done_d;
         flush_q     <= flush_d;
         mis_q       <= mis_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign br_ready       = (state_q == ST_IDLE);
   assign redirect_valid = (state_q == ST_REDIRECT);
   assign redirect_pc    = redir_pc_q;
   assign flush_if_id    = flush_q;
   assign done           = done_q;
   assign misalign       = mis_q;
   assign br_cnt         = br_cnt_q;
   assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: vector table of branch outcomes plus
// hand-built operand-delay, redirect-stall, kill, wrap and async-reset sequences.
module tb_branch_ctrl;
   import branch_ctrl_pkg::*;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             br_valid;
   logic             br_ready;
   br_op_e           br_op;
   logic [XLEN-1:0]  br_pc, br_imm;
   logic             rs1_rdy, rs2_rdy;
   logic [XLEN-1:0]  rs1_val, rs2_val;
   logic             kill;
   logic             redirect_valid;
   logic             redirect_ready;
   logic [XLEN-1:0]  redirect_pc;
   logic             flush_if_id, done, misalign;
   logic [CNT_W-1:0] br_cnt, taken_cnt;

   branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_op          (br_op),
      .br_pc          (br_pc),
      .br_imm         (br_imm),
      .rs1_rdy        (rs1_rdy),
      .rs2_rdy        (rs2_rdy),
      .rs1_val        (rs1_val),
      .rs2_val        (rs2_val),
      .kill           (kill),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .flush_if_id    (flush_if_id),
      .done           (done),
      .misalign       (misalign),
      .br_cnt         (br_cnt),
      .taken_cnt      (taken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      br_op_e          op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      bit              taken;
   } vec_t;

   typedef struct {
      bit              taken;
      bit              mis;
      bit              killed;
      logic [XLEN-1:0] tgt;
      int              done_cyc;
      int              flush_cyc;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[15];

   int n_checks = 0;
   int n_fail   = 0;
   int br_cnt_m = 0;
   int tk_cnt_m = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic drive_idle();
      br_valid       = 1'b0;
      br_op          = BR_NONE;
      br_pc          = '0;
      br_imm         = '0;
      rs1_rdy        = 1'b0;
      rs2_rdy        = 1'b0;
      rs1_val        = '0;
      rs2_val        = '0;
      kill           = 1'b0;
      redirect_ready = 1'b0;
   endtask

   task automatic check_counts(input string tag);
      logic [CNT_W-1:0] eb, et;
      eb = CNT_W'(br_cnt_m);
      et = CNT_W'(tk_cnt_m);
      check({tag, "_br_cnt"}, 64'(br_cnt), 64'(eb));
      check({tag, "_taken_cnt"}, 64'(taken_cnt), 64'(et));
   endtask

   // Operands become ready in cycle d1/d2 (0 = acceptance cycle) and stay ready with
   // a different value afterwards; redirect_ready rises in cycle rr_from; kill pulses
   // in cycle kill_at (negative = never).
   task automatic run(input string tag, input vec_t v, input int d1, input int d2,
                      input int rr_from, input int kill_at);
      exp_t e, got;
      int   m, done_at, flush_at, mis_at, flush_n;
      bit   rv_seen, rpc_bad;
      e.taken     = v.taken;
      e.tgt       = v.pc + v.imm;
      e.mis       = v.taken && (e.tgt[1:0] != 2'b00);
      e.killed    = (kill_at > 0);
      m           = (d1 > d2) ? d1 : d2;
      e.flush_cyc = (v.taken && !e.mis) ? m + 2 : -1;
      if (!v.taken || e.mis) e.done_cyc = m + 2;
      else                   e.done_cyc = ((m + 2 > rr_from) ? m + 2 : rr_from) + 1;
      exp_q.push_back(e);

      @(negedge clk);
      check({tag, "_ready_idle"}, 64'(br_ready), 64'd1);
      br_valid       = 1'b1;
      br_op          = v.op;
      br_pc          = v.pc;
      br_imm         = v.imm;
      rs1_rdy        = (d1 == 0);
      rs1_val        = (d1 == 0) ? v.a : ~v.a;
      rs2_rdy        = (d2 == 0);
      rs2_val        = (d2 == 0) ? v.b : ~v.b;
      redirect_ready = (rr_from <= 0);
      kill           = (kill_at == 0);

      done_at = -1; flush_at = -1; mis_at = -1; flush_n = 0;
      rv_seen = 1'b0; rpc_bad = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done && done_at < 0) done_at = k;
         if (flush_if_id) begin
            flush_n++;
            if (flush_at < 0) flush_at = k;
         end
         if (misalign && mis_at < 0) mis_at = k;
         if (redirect_valid) begin
            rv_seen = 1'b1;
            if (redirect_pc !== e.tgt) rpc_bad = 1'b1;
         end
         if (k == 1) check({tag, "_ready_busy"}, 64'(br_ready), 64'd0);
         if (e.killed && k == kill_at + 1) begin
            check({tag, "_kill_ready"}, 64'(br_ready), 64'd1);
            check({tag, "_kill_rvalid"}, 64'(redirect_valid), 64'd0);
         end
         br_valid       = 1'b0;
         rs1_rdy        = (k >= d1);
         rs1_val        = (k == d1) ? v.a : ~v.a;
         rs2_rdy        = (k >= d2);
         rs2_val        = (k == d2) ? v.b : ~v.b;
         redirect_ready = (k >= rr_from);
         kill           = (k == kill_at);
         if (done_at >= 0) break;
         if (e.killed && k >= kill_at + 3) break;
      end
      drive_idle();

      got = exp_q.pop_front();
      if (got.killed) begin
         check({tag, "_kill_no_done"}, 64'(done_at), 64'(-1));
         check({tag, "_kill_no_mis"}, 64'(mis_at), 64'(-1));
      end else begin
         br_cnt_m++;
         if (got.taken) tk_cnt_m++;
         check({tag, "_done_cycle"}, 64'(done_at), 64'(got.done_cyc));
         check({tag, "_mis_cycle"}, 64'(mis_at), got.mis ? 64'(got.done_cyc) : 64'(-1));
         check({tag, "_flush_cycle"}, 64'(flush_at), 64'(got.flush_cyc));
         check({tag, "_flush_pulses"}, 64'(flush_n), (got.flush_cyc >= 0) ? 64'd1 : 64'd0);
         check({tag, "_rvalid_seen"}, 64'(rv_seen), 64'(got.taken && !got.mis));
         check({tag, "_rpc_stable"}, 64'(rpc_bad), 64'd0);
      end
      check_counts(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t nt;
      vecs[0]  = '{BR_BEQ,  64'd5, 64'd5, 64'h1000, 64'h40, 1'b1};
      vecs[1]  = '{BR_BEQ,  64'd5, 64'd6, 64'h1000, 64'h40, 1'b0};
      vecs[2]  = '{BR_BNE,  64'd5, 64'd6, 64'h2000, 64'h10, 1'b1};
      vecs[3]  = '{BR_BLT,  -64'sd1, 64'd1, 64'h3000, -64'sd8, 1'b1};
      vecs[4]  = '{BR_BLTU, -64'sd1, 64'd1, 64'h3000, -64'sd8, 1'b0};
      vecs[5]  = '{BR_BGE,  64'd1, -64'sd1, 64'h100, 64'h20, 1'b1};
      vecs[6]  = '{BR_BGE,  64'd3, 64'd3, 64'h400, 64'h4, 1'b1};
      vecs[7]  = '{BR_BGEU, 64'd1, -64'sd1, 64'h400, 64'h4, 1'b0};
      vecs[8]  = '{BR_BLTU, 64'd1, -64'sd1, 64'h10, -64'sd16, 1'b1};
      vecs[9]  = '{BR_BGEU, -64'sd1, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b1};
      vecs[10] = '{BR_NONE, 64'd5, 64'd5, 64'h500, 64'h8, 1'b0};
      vecs[11] = '{BR_RSVD, 64'd5, 64'd5, 64'h500, 64'h8, 1'b0};
      vecs[12] = '{BR_BNE,  64'd1, 64'd2, 64'h1000, 64'h2, 1'b1};
      vecs[13] = '{BR_BLT,  64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h800, 64'h100, 1'b1};
      vecs[14] = '{BR_BLT,  64'd2, 64'd2, 64'h800, 64'h100, 1'b0};

      drive_idle();
      rst_n = 1'b0;
      #1;
      check("por_ready", 64'(br_ready), 64'd1);
      check("por_rvalid", 64'(redirect_valid), 64'd0);
      check("por_done", 64'(done), 64'd0);
      check_counts("por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++)
         run($sformatf("vec%0d", i), vecs[i], 0, 0, 0, -1);

      run("late_rs2", '{BR_BLT, -64'sd5, 64'd3, 64'h40, 64'h8, 1'b1}, 0, 4, 0, -1);
      run("late_rs1", '{BR_BGE, 64'd7, 64'd9, 64'h40, 64'h8, 1'b0}, 3, 1, 0, -1);
      run("rr_stall", vecs[0], 0, 0, 5, -1);
      run("kill_redir", vecs[0], 0, 0, 5, 3);
      run("kill_wait", vecs[2], 0, 5, 0, 2);
      run("kill_resolve", vecs[3], 0, 0, 0, 1);
      run("kill_idle", vecs[5], 0, 0, 0, 0);

      nt = vecs[1];
      for (int i = 0; br_cnt_m < 258 && i < 400; i++)
         run("wrap", nt, 0, 0, 0, -1);

      // Async reset while waiting on rs2.
      @(negedge clk);
      br_valid = 1'b1; br_op = BR_BEQ; br_pc = 64'h2000; br_imm = 64'h20;
      rs1_rdy = 1'b1; rs1_val = 64'd9; rs2_rdy = 1'b0;
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      check("rst_pre_busy", 64'(br_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      br_cnt_m = 0;
      tk_cnt_m = 0;
      check("rst_ready", 64'(br_ready), 64'd1);
      check("rst_rvalid", 64'(redirect_valid), 64'd0);
      check("rst_rpc", redirect_pc, 64'd0);
      check("rst_flush", 64'(flush_if_id), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_mis", 64'(misalign), 64'd0);
      check_counts("rst");
      @(negedge clk);
      rst_n = 1'b1;
      run("post_rst", vecs[0], 0, 0, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
